// File: rtl/sopc_data_bus_if.sv
// Request/response channel of the SoPC data bus: master-side request and
// response signals plus the shared slave-side strobe, write and ack lines.
interface sopc_data_bus_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_SLAVES = 4
);
    logic                         m_ce_i;
    logic                         m_we_i;
    logic [ADDR_W-1:0]            m_addr_i;
    logic [DATA_W/8-1:0]          m_sel_i;
    logic [DATA_W-1:0]            m_data_i;
    logic [DATA_W-1:0]            m_data_o;
    logic                         m_stall_o;
    logic                         m_err_o;

    logic [NUM_SLAVES-1:0]        s_ce_o;
    logic                         s_we_o;
    logic [ADDR_W-1:0]            s_addr_o;
    logic [DATA_W/8-1:0]          s_sel_o;
    logic [DATA_W-1:0]            s_data_o;
    logic [NUM_SLAVES*DATA_W-1:0] s_data_i;
    logic [NUM_SLAVES-1:0]        s_ack_i;

    // Environment view: issues master requests and models the slaves.
    modport master (
        output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
        input  m_data_o, m_stall_o, m_err_o,
        input  s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
        output s_data_i, s_ack_i
    );

    // Bus controller view.
    modport slave (
        input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
        output m_data_o, m_stall_o, m_err_o,
        output s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
        input  s_data_i, s_ack_i
    );
endinterface

// File: rtl/sopc_data_bus.sv
// Single-master SoPC data bus: decodes a 3-bit slave index from the address,
// strobes one slave until it acks or times out, then gives a one-cycle response.
module sopc_data_bus #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_LSB    = 28,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic            clk,
    input logic            rst,
    sopc_data_bus_if.slave bus
);
    localparam int unsigned SelW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [2:0]          idx_q, idx_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [2:0]          req_idx;
    logic                ack_sel;
    logic [DATA_W-1:0]   slv_rdata;

    assign req_idx = bus.m_addr_i[SEL_LSB+2:SEL_LSB];

    // Only the addressed slave's ack and data are visible to the FSM.
    always_comb begin
        ack_sel   = 1'b0;
        slv_rdata = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (idx_q == 3'(k)) begin
                ack_sel   = bus.s_ack_i[k];
                slv_rdata = bus.s_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.m_ce_i) begin
                    we_d    = bus.m_we_i;
                    addr_d  = bus.m_addr_i;
                    sel_d   = bus.m_sel_i;
                    wdata_d = bus.m_data_i;
                    idx_d   = req_idx;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (32'(req_idx) < NUM_SLAVES) begin
                        state_d = StReq;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                if (ack_sel) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : slv_rdata;
                end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                err_d   = 1'b0;
                rdata_d = '0;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.s_ce_o = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            bus.s_ce_o[k] = (state_q == StReq) && (idx_q == 3'(k));
        end
    end

    assign bus.s_we_o    = we_q;
    assign bus.s_addr_o  = addr_q;
    assign bus.s_sel_o   = sel_q;
    assign bus.s_data_o  = wdata_q;
    assign bus.m_stall_o = bus.m_ce_i && (state_q != StResp);
    assign bus.m_data_o  = (state_q == StResp) ? rdata_q : '0;
    assign bus.m_err_o   = (state_q == StResp) && err_q;
endmodule

// File: tb/tb_sopc_data_bus.sv
// Randomized self-checking bench for sopc_data_bus; expected responses come from
// a transaction-level model of decode, ack latency and timeout.
module tb_sopc_data_bus;
    localparam int NS  = 4;
    localparam int TMO = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] sdata [NS];

    sopc_data_bus_if #(.DATA_W(32), .ADDR_W(32), .NUM_SLAVES(NS)) bus ();

    sopc_data_bus #(
        .DATA_W(32), .ADDR_W(32), .NUM_SLAVES(NS), .SEL_LSB(28), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_slaves();
        for (int k = 0; k < NS; k++) begin
            sdata[k] = $urandom;
            bus.s_data_i[k*32 +: 32] = sdata[k];
        end
    endtask

    // Runs one transaction starting just after a rising edge, with the DUT idle.
    // ack_port < 0 means no slave acks; the ack is a single-cycle pulse in REQ
    // cycle number ack_after (0-based).
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input int ack_after, input int ack_port, input bit scramble);
        int          idx;
        int          resp_c;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_ce;
        logic        exp_stall;

        idx = int'(addr[30:28]);
        if (idx >= NS) begin
            resp_c = 1; exp_err = 1'b1; exp_rd = '0;
        end else if (ack_port == idx && ack_after < TMO) begin
            resp_c = ack_after + 2; exp_err = 1'b0; exp_rd = we ? 32'h0 : sdata[idx];
        end else begin
            resp_c = TMO + 1; exp_err = 1'b1; exp_rd = '0;
        end

        bus.m_ce_i   = 1'b1;
        bus.m_we_i   = we;
        bus.m_addr_i = addr;
        bus.m_sel_i  = sel;
        bus.m_data_i = wdata;
        for (int c = 0; c <= resp_c; c++) begin
            if (c >= 1 && scramble) begin
                bus.m_ce_i   = 1'($urandom_range(0, 1));
                bus.m_we_i   = 1'($urandom_range(0, 1));
                bus.m_addr_i = $urandom;
                bus.m_sel_i  = 4'($urandom);
                bus.m_data_i = $urandom;
            end
            bus.s_ack_i = '0;
            if (c >= 1 && c - 1 == ack_after && ack_port >= 0) bus.s_ack_i[ack_port] = 1'b1;
            @(negedge clk);
            exp_ce    = (c >= 1 && c < resp_c) ? 4'(1 << idx) : 4'b0;
            exp_stall = bus.m_ce_i && (c != resp_c);
            checks++;
            if (bus.s_ce_o !== exp_ce) begin
                errors++;
                $display("FAIL %s s_ce_o cycle %0d: got %b expected %b", name, c, bus.s_ce_o, exp_ce);
            end
            checks++;
            if (bus.m_stall_o !== exp_stall) begin
                errors++;
                $display("FAIL %s m_stall_o cycle %0d: got %b expected %b", name, c,
                         bus.m_stall_o, exp_stall);
            end
            checks++;
            if (bus.m_err_o !== ((c == resp_c) ? exp_err : 1'b0)) begin
                errors++;
                $display("FAIL %s m_err_o cycle %0d: got %b expected %b", name, c, bus.m_err_o,
                         (c == resp_c) ? exp_err : 1'b0);
            end
            checks++;
            if (bus.m_data_o !== ((c == resp_c) ? exp_rd : 32'h0)) begin
                errors++;
                $display("FAIL %s m_data_o cycle %0d: got %h expected %h", name, c, bus.m_data_o,
                         (c == resp_c) ? exp_rd : 32'h0);
            end
            if (c >= 1 && c < resp_c) begin
                checks++;
                if ({bus.s_we_o, bus.s_addr_o, bus.s_sel_o, bus.s_data_o} !== {we, addr, sel, wdata}) begin
                    errors++;
                    $display("FAIL %s latched request cycle %0d: got we=%b a=%h s=%b d=%h expected we=%b a=%h s=%b d=%h",
                             name, c, bus.s_we_o, bus.s_addr_o, bus.s_sel_o, bus.s_data_o,
                             we, addr, sel, wdata);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.m_ce_i  = 1'b0;
        bus.s_ack_i = '0;
    endtask

    task automatic check_reset_outputs(input string name, input logic exp_stall);
        checks++;
        if (bus.s_ce_o !== 4'b0 || bus.m_err_o !== 1'b0 || bus.m_data_o !== 32'h0) begin
            errors++;
            $display("FAIL %s outputs: got ce=%b err=%b data=%h expected ce=0000 err=0 data=0",
                     name, bus.s_ce_o, bus.m_err_o, bus.m_data_o);
        end
        checks++;
        if ({bus.s_we_o, bus.s_addr_o, bus.s_sel_o, bus.s_data_o} !== 69'h0) begin
            errors++;
            $display("FAIL %s latched regs: got we=%b a=%h s=%b d=%h expected all 0", name,
                     bus.s_we_o, bus.s_addr_o, bus.s_sel_o, bus.s_data_o);
        end
        checks++;
        if (bus.m_stall_o !== exp_stall) begin
            errors++;
            $display("FAIL %s m_stall_o: got %b expected %b", name, bus.m_stall_o, exp_stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.m_ce_i = 1'b0; bus.m_we_i = 1'b0; bus.m_addr_i = '0;
        bus.m_sel_i = '0; bus.m_data_i = '0; bus.s_ack_i = '0;
        load_slaves();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_idle", 1'b0);
        bus.m_ce_i = 1'b1;
        #1;
        check_reset_outputs("reset_stall", 1'b1);
        bus.m_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        load_slaves();
        sdata[1] = 32'hDEADBEEF;
        bus.s_data_i[32 +: 32] = 32'hDEADBEEF;
        do_txn("read_slave1", 1'b0, 32'h1000_0004, 4'hF, 32'h0, 0, 1, 1'b0);
        do_txn("write_slave2", 1'b1, 32'h2000_0000, 4'b0011, 32'h12345678, 2, 2, 1'b0);
        do_txn("decode_error", 1'b0, 32'h7000_0000, 4'hF, 32'h0, 0, 0, 1'b0);
        do_txn("timeout", 1'b0, 32'h1000_0000, 4'hF, 32'h0, 0, -1, 1'b0);
        do_txn("wrong_ack", 1'b0, 32'h3000_0000, 4'hF, 32'h0, 0, 0, 1'b0);
        do_txn("ack_last_cycle", 1'b0, 32'h0000_0040, 4'hF, 32'h0, TMO - 1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_slaves();
        bus.m_ce_i = 1'b1; bus.m_we_i = 1'b0;
        bus.m_addr_i = 32'h1000_0008; bus.m_sel_i = 4'hF; bus.m_data_i = 32'hA5A5A5A5;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_req", 1'b1);
        bus.m_ce_i = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_hold", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_txn("rst_recover", 1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_slaves();
        for (int i = 0; i < 4; i++) begin
            do_txn("back_to_back", 1'b0, {4'h0, 2'(i), 26'h40}, 4'hF, 32'h0, 0, i, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          port;
        for (int i = 0; i < 40; i++) begin
            load_slaves();
            addr = $urandom;
            port = ($urandom_range(0, 9) < 7) ? int'(addr[30:28]) : int'($urandom_range(0, NS - 1));
            if (port >= NS) port = int'($urandom_range(0, NS - 1));
            do_txn("random", 1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom,
                   int'($urandom_range(0, TMO + 1)), port, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
